// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and BCD limits for the match timer
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with borrow chaining
module bcd_down_digit
    import pong_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_DIGIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    assign borrow_out = dec_in && (digit == 4'd0);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            digit <= load_val;
        end else if (dec_in) begin
            digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/match_timer.sv
// rtl/match_timer.sv - MM:SS BCD countdown match clock driven by an edge-detected 1 Hz input
// Optional low-time indicator enabled by MATCH_TIMER_WARN_EN.
module match_timer
    import pong_pkg::*;
#(
    parameter int unsigned START_MIN = 2,
    parameter int unsigned START_SEC = 0,
    parameter int unsigned WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1Hz,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       time_up
`ifdef MATCH_TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    localparam logic [3:0] LV_MT = 4'(START_MIN / 10);
    localparam logic [3:0] LV_MO = 4'(START_MIN % 10);
    localparam logic [3:0] LV_ST = 4'(START_SEC / 10);
    localparam logic [3:0] LV_SO = 4'(START_SEC % 10);

    state_t state;
    logic   clk_1Hz_q;
    logic   tick_r;
    logic   dec;
    logic   is_zero;
    logic   at_one;
    logic   b_so, b_st, b_mo, b_mt;

    assign is_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    assign at_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    // Ticks only count in RUN with no competing command; the zero guard stops any wrap to 99:59.
    assign dec = tick_r && (state == ST_RUN) && !load && !pause && !is_zero;

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    bcd_down_digit #(.MAX(BCD_MAX_DIGIT)) u_sec_ones (
        .clk(clk), .rst(rst), .load(load), .load_val(LV_SO),
        .dec_in(dec), .digit(sec_ones), .borrow_out(b_so)
    );

    bcd_down_digit #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
        .clk(clk), .rst(rst), .load(load), .load_val(LV_ST),
        .dec_in(b_so), .digit(sec_tens), .borrow_out(b_st)
    );

    bcd_down_digit #(.MAX(BCD_MAX_DIGIT)) u_min_ones (
        .clk(clk), .rst(rst), .load(load), .load_val(LV_MO),
        .dec_in(b_st), .digit(min_ones), .borrow_out(b_mo)
    );

    bcd_down_digit #(.MAX(BCD_MAX_DIGIT)) u_min_tens (
        .clk(clk), .rst(rst), .load(load), .load_val(LV_MT),
        .dec_in(b_mo), .digit(min_tens), .borrow_out(b_mt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            clk_1Hz_q <= 1'b0;
            tick_r    <= 1'b0;
            time_up   <= 1'b0;
        end else begin
            clk_1Hz_q <= clk_1Hz;
            tick_r    <= clk_1Hz && !clk_1Hz_q;
            time_up   <= 1'b0;
            if (load) begin
                state <= ST_IDLE;
            end else if (pause) begin
                if (state == ST_RUN) begin
                    state <= ST_PAUSE;
                end
            end else if (start && (state == ST_IDLE || state == ST_PAUSE)) begin
                if (state == ST_IDLE && is_zero) begin
                    state   <= ST_DONE;
                    time_up <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end else if (state == ST_RUN && tick_r && at_one) begin
                state   <= ST_DONE;
                time_up <= 1'b1;
            end
        end
    end

`ifdef MATCH_TIMER_WARN_EN
    logic [13:0] remaining;
    logic        warn_r;

    assign remaining = 14'(min_tens) * 14'd600 + 14'(min_ones) * 14'd60
                     + 14'(sec_tens) * 14'd10 + 14'(sec_ones);

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= (state == ST_RUN || state == ST_PAUSE) && (remaining <= 14'(WARN_SEC));
        end
    end

    // Masked by the live state so warn drops in the same cycle DONE (or IDLE) is entered.
    assign warn = warn_r && (state == ST_RUN || state == ST_PAUSE);
`endif

    logic unused_ok;
    assign unused_ok = b_mt;

endmodule
